// File: rtl/wb_stage.sv
// ----------------------------------------------------------------------------
// wb_stage: MEM/WB pipeline register and writeback select for the 5-stage
// MIPS core. It drives the register-file write port (rd, write_data_in,
// WriteEnable) and merges late multicycle-unit results through a one-entry
// buffer.
//
// Optional feature: define WB_BYPASS_EN to add the same-cycle ID bypass
// ports (byp_rs_*/byp_rt_*). The default build has no bypass logic.
//
// Ports:
//   clock, reset          clock and synchronous active-high reset
//   stall, flush          hold / kill the instruction entering MEM/WB
//   mem_*                 MEM-stage instruction fields captured into the slot
//   late_valid/rd/data    result offered by the multicycle unit
//   late_ready            late buffer is empty and can accept a result
//   rd, write_data_in,    register-file write port; rd/write_data_in hold
//   WriteEnable           their last driven values while WriteEnable=0
// ----------------------------------------------------------------------------
module wb_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              mem_valid,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [1:0]        mem_wb_sel,
    input  logic [DATA_W-1:0] mem_alu_result,
    input  logic [DATA_W-1:0] mem_load_data,
    input  logic [1:0]        mem_load_size,
    input  logic              mem_load_unsigned,
    input  logic [DATA_W-1:0] mem_pc_plus8,
    input  logic              late_valid,
    input  logic [REG_AW-1:0] late_rd,
    input  logic [DATA_W-1:0] late_data,
    output logic              late_ready,
`ifdef WB_BYPASS_EN
    input  logic [REG_AW-1:0] byp_rs_addr,
    input  logic [REG_AW-1:0] byp_rt_addr,
    input  logic [DATA_W-1:0] byp_rs_in,
    input  logic [DATA_W-1:0] byp_rt_in,
    output logic [DATA_W-1:0] byp_rs_out,
    output logic [DATA_W-1:0] byp_rt_out,
`endif
    output logic [REG_AW-1:0] rd,
    output logic [DATA_W-1:0] write_data_in,
    output logic              WriteEnable
);

    localparam logic [1:0] SEL_LOAD = 2'd1;
    localparam logic [1:0] SEL_LINK = 2'd2;

    // WB slot
    logic              slot_valid_reg;
    logic              slot_reg_write_reg;
    logic [REG_AW-1:0] slot_rd_reg;
    logic [1:0]        slot_wb_sel_reg;
    logic [DATA_W-1:0] slot_alu_reg;
    logic [DATA_W-1:0] slot_load_data_reg;
    logic [1:0]        slot_load_size_reg;
    logic              slot_load_unsigned_reg;
    logic [DATA_W-1:0] slot_pc8_reg;

    // Late-result buffer
    logic              buf_full_reg;
    logic [REG_AW-1:0] buf_rd_reg;
    logic [DATA_W-1:0] buf_data_reg;

    // Last driven write-port values, so the port never floats to X when idle
    logic [REG_AW-1:0] last_rd_reg;
    logic [DATA_W-1:0] last_data_reg;

    logic              slot_wr;
    logic [DATA_W-1:0] slot_data;
    logic [DATA_W-1:0] load_value;
    logic [1:0]        load_off;

    logic              we_next;
    logic [REG_AW-1:0] rd_next;
    logic [DATA_W-1:0] data_next;

    // ------------------------------------------------------------------
    // Slot capture: stall beats flush
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            slot_valid_reg         <= 1'b0;
            slot_reg_write_reg     <= 1'b0;
            slot_rd_reg            <= '0;
            slot_wb_sel_reg        <= '0;
            slot_alu_reg           <= '0;
            slot_load_data_reg     <= '0;
            slot_load_size_reg     <= '0;
            slot_load_unsigned_reg <= 1'b0;
            slot_pc8_reg           <= '0;
        end else if (!stall) begin
            if (flush) begin
                slot_valid_reg <= 1'b0;
            end else begin
                slot_valid_reg         <= mem_valid;
                slot_reg_write_reg     <= mem_reg_write;
                slot_rd_reg            <= mem_rd;
                slot_wb_sel_reg        <= mem_wb_sel;
                slot_alu_reg           <= mem_alu_result;
                slot_load_data_reg     <= mem_load_data;
                slot_load_size_reg     <= mem_load_size;
                slot_load_unsigned_reg <= mem_load_unsigned;
                slot_pc8_reg           <= mem_pc_plus8;
            end
        end
    end

    // ------------------------------------------------------------------
    // Load alignment (little-endian lanes)
    // ------------------------------------------------------------------
    logic [7:0]  byte_lane [4];
    logic [15:0] half_lane [2];

    for (genvar gi = 0; gi < 4; gi++) begin : g_byte_lane
        assign byte_lane[gi] = slot_load_data_reg[8*gi +: 8];
    end
    for (genvar gi = 0; gi < 2; gi++) begin : g_half_lane
        assign half_lane[gi] = slot_load_data_reg[16*gi +: 16];
    end

    assign load_off = slot_alu_reg[1:0];

    always_comb begin
        logic [7:0]  b;
        logic [15:0] h;
        b          = byte_lane[load_off];
        h          = half_lane[load_off[1]];
        load_value = slot_load_data_reg;
        case (slot_load_size_reg)
            2'd0:    load_value = {{(DATA_W-8){b[7] & ~slot_load_unsigned_reg}}, b};
            2'd1:    load_value = {{(DATA_W-16){h[15] & ~slot_load_unsigned_reg}}, h};
            default: load_value = slot_load_data_reg;
        endcase
    end

    // Reserved select 3 falls through to the ALU result
    always_comb begin
        case (slot_wb_sel_reg)
            SEL_LOAD: slot_data = load_value;
            SEL_LINK: slot_data = slot_pc8_reg;
            default:  slot_data = slot_alu_reg;
        endcase
    end

    assign slot_wr = slot_valid_reg & slot_reg_write_reg & (slot_rd_reg != '0);

    // ------------------------------------------------------------------
    // Write-port arbitration: pipeline slot first, then the late buffer
    // ------------------------------------------------------------------
    always_comb begin
        we_next   = 1'b0;
        rd_next   = last_rd_reg;
        data_next = last_data_reg;
        if (slot_wr) begin
            we_next   = 1'b1;
            rd_next   = slot_rd_reg;
            data_next = slot_data;
        end else if (buf_full_reg) begin
            we_next   = 1'b1;
            rd_next   = buf_rd_reg;
            data_next = buf_data_reg;
        end
    end

    assign WriteEnable   = we_next;
    assign rd            = rd_next;
    assign write_data_in = data_next;
    assign late_ready    = ~buf_full_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            last_rd_reg   <= '0;
            last_data_reg <= '0;
        end else if (we_next) begin
            last_rd_reg   <= rd_next;
            last_data_reg <= data_next;
        end
    end

    // ------------------------------------------------------------------
    // Late buffer. Since ready = empty, a fill and a drain can never
    // happen at the same edge. A slot write to the same rd retires the
    // buffered (older) value so it cannot overwrite the younger one.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            buf_full_reg <= 1'b0;
            buf_rd_reg   <= '0;
            buf_data_reg <= '0;
        end else if (buf_full_reg) begin
            if (!slot_wr || (slot_rd_reg == buf_rd_reg)) begin
                buf_full_reg <= 1'b0;
            end
        end else if (late_valid && (late_rd != '0)) begin
            buf_full_reg <= 1'b1;
            buf_rd_reg   <= late_rd;
            buf_data_reg <= late_data;
        end
    end

`ifdef WB_BYPASS_EN
    // Forward the value being written this cycle to ID readers
    assign byp_rs_out = (we_next && (rd_next != '0) && (byp_rs_addr == rd_next))
                        ? data_next : byp_rs_in;
    assign byp_rt_out = (we_next && (rd_next != '0) && (byp_rt_addr == rd_next))
                        ? data_next : byp_rt_in;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// ----------------------------------------------------------------------------
// tb_wb_stage: directed self-checking bench for wb_stage. Each step drives
// stimulus, pushes the expected write-port state for the following cycle to
// a scoreboard queue, then pops and compares it 1 ns after the clock edge.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wb_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall, flush;
    logic        mem_valid, mem_reg_write;
    logic [4:0]  mem_rd;
    logic [1:0]  mem_wb_sel;
    logic [31:0] mem_alu_result, mem_load_data, mem_pc_plus8;
    logic [1:0]  mem_load_size;
    logic        mem_load_unsigned;
    logic        late_valid;
    logic [4:0]  late_rd;
    logic [31:0] late_data;
    logic        late_ready;
    logic [4:0]  rd;
    logic [31:0] write_data_in;
    logic        WriteEnable;
`ifdef WB_BYPASS_EN
    logic [4:0]  byp_rs_addr = 5'd0, byp_rt_addr = 5'd0;
    logic [31:0] byp_rs_in = 32'd0, byp_rt_in = 32'd0;
    logic [31:0] byp_rs_out, byp_rt_out;
`endif

    always #5 clock = ~clock;

    wb_stage dut (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush),
        .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
        .mem_wb_sel(mem_wb_sel), .mem_alu_result(mem_alu_result),
        .mem_load_data(mem_load_data), .mem_load_size(mem_load_size),
        .mem_load_unsigned(mem_load_unsigned), .mem_pc_plus8(mem_pc_plus8),
        .late_valid(late_valid), .late_rd(late_rd), .late_data(late_data),
        .late_ready(late_ready),
`ifdef WB_BYPASS_EN
        .byp_rs_addr(byp_rs_addr), .byp_rt_addr(byp_rt_addr),
        .byp_rs_in(byp_rs_in), .byp_rt_in(byp_rt_in),
        .byp_rs_out(byp_rs_out), .byp_rt_out(byp_rt_out),
`endif
        .rd(rd), .write_data_in(write_data_in), .WriteEnable(WriteEnable)
    );

    typedef struct {
        string       tag;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        ready;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    logic [4:0]  last_rd = 5'd0;
    logic [31:0] last_data = 32'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_cycle();
        exp_t e;
        @(posedge clock);
        #1;
        e = sb.pop_front();
        chk({e.tag, ".we"},    {31'd0, WriteEnable}, {31'd0, e.we});
        chk({e.tag, ".rd"},    {27'd0, rd},          {27'd0, e.rd});
        chk({e.tag, ".data"},  write_data_in,        e.data);
        chk({e.tag, ".ready"}, {31'd0, late_ready},  {31'd0, e.ready});
        $display("[TB] %s: we=%0b rd=%0d data=%h ready=%0b", e.tag, WriteEnable, rd, write_data_in, late_ready);
    endtask

    // Expect a write of d to register r after the next edge
    task automatic step_w(input string tag, input logic [4:0] r, input logic [31:0] d, input logic rdy);
        exp_t e;
        e.tag = tag; e.we = 1'b1; e.rd = r; e.data = d; e.ready = rdy;
        last_rd = r; last_data = d;
        sb.push_back(e);
        run_cycle();
    endtask

    // Expect no write; port holds the last driven values
    task automatic step_n(input string tag, input logic rdy);
        exp_t e;
        e.tag = tag; e.we = 1'b0; e.rd = last_rd; e.data = last_data; e.ready = rdy;
        sb.push_back(e);
        run_cycle();
    endtask

    task automatic idle();
        mem_valid = 1'b0; mem_reg_write = 1'b0; late_valid = 1'b0;
        stall = 1'b0; flush = 1'b0;
    endtask

    task automatic mem_op(input logic [4:0] r, input logic [1:0] sel, input logic [31:0] alu,
                          input logic [31:0] ld, input logic [1:0] size, input logic uns,
                          input logic [31:0] pc8);
        mem_valid = 1'b1; mem_reg_write = 1'b1; mem_rd = r; mem_wb_sel = sel;
        mem_alu_result = alu; mem_load_data = ld; mem_load_size = size;
        mem_load_unsigned = uns; mem_pc_plus8 = pc8;
    endtask

    task automatic late(input logic [4:0] r, input logic [31:0] d);
        late_valid = 1'b1; late_rd = r; late_data = d;
    endtask

    initial begin
        idle();
        mem_rd = 5'd0; mem_wb_sel = 2'd0; mem_alu_result = 32'd0; mem_load_data = 32'd0;
        mem_load_size = 2'd0; mem_load_unsigned = 1'b0; mem_pc_plus8 = 32'd0;
        late_rd = 5'd0; late_data = 32'd0;

        // Reset state
        reset = 1'b1;
        last_rd = 5'd0; last_data = 32'd0;
        step_n("reset", 1'b1);
        reset = 1'b0;

        // ALU write then idle
        mem_op(5'd5, 2'd0, 32'h1234_5678, 32'd0, 2'd2, 1'b0, 32'd0);
        step_w("alu_r5", 5'd5, 32'h1234_5678, 1'b1);
        idle();
        step_n("alu_idle", 1'b1);

        // Loads
        mem_op(5'd6, 2'd1, 32'h0000_0003, 32'h80AA_BBCC, 2'd0, 1'b0, 32'd0);
        step_w("lb_off3_s", 5'd6, 32'hFFFF_FF80, 1'b1);
        mem_op(5'd6, 2'd1, 32'h0000_0003, 32'h80AA_BBCC, 2'd0, 1'b1, 32'd0);
        step_w("lb_off3_u", 5'd6, 32'h0000_0080, 1'b1);
        mem_op(5'd6, 2'd1, 32'h0000_0001, 32'h80AA_BBCC, 2'd0, 1'b0, 32'd0);
        step_w("lb_off1_s", 5'd6, 32'hFFFF_FFBB, 1'b1);
        mem_op(5'd7, 2'd1, 32'h0000_0002, 32'h7FFF_0000, 2'd1, 1'b0, 32'd0);
        step_w("lh_off2_s", 5'd7, 32'h0000_7FFF, 1'b1);
        mem_op(5'd7, 2'd1, 32'h0000_0003, 32'h8001_0000, 2'd1, 1'b0, 32'd0);
        step_w("lh_off3_s", 5'd7, 32'hFFFF_8001, 1'b1);
        mem_op(5'd7, 2'd1, 32'h0000_0000, 32'h1234_8001, 2'd1, 1'b1, 32'd0);
        step_w("lh_off0_u", 5'd7, 32'h0000_8001, 1'b1);
        mem_op(5'd7, 2'd1, 32'h0000_0001, 32'hCAFE_F00D, 2'd3, 1'b0, 32'd0);
        step_w("lw_off1", 5'd7, 32'hCAFE_F00D, 1'b1);

        // Writes to $0 are suppressed; link and reserved select
        mem_op(5'd0, 2'd0, 32'hFFFF_FFFF, 32'd0, 2'd2, 1'b0, 32'd0);
        step_n("r0_write", 1'b1);
        mem_op(5'd31, 2'd2, 32'h1111_1111, 32'd0, 2'd2, 1'b0, 32'h0040_0010);
        step_w("link_r31", 5'd31, 32'h0040_0010, 1'b1);
        mem_op(5'd3, 2'd3, 32'h3333_3333, 32'h4444_4444, 2'd2, 1'b0, 32'h5555_5555);
        step_w("sel3_alu", 5'd3, 32'h3333_3333, 1'b1);

        // Late result accepted while slot writes r9; drains next idle cycle
        mem_op(5'd9, 2'd0, 32'h0000_0099, 32'd0, 2'd2, 1'b0, 32'd0);
        late(5'd8, 32'hDEAD_BEEF);
        step_w("late_slot_r9", 5'd9, 32'h0000_0099, 1'b0);
        idle();
        step_w("late_drain_r8", 5'd8, 32'hDEAD_BEEF, 1'b0);
        step_n("late_empty", 1'b1);

        // late_rd=0 is discarded
        late(5'd0, 32'h0BAD_0BAD);
        step_n("late_rd0", 1'b1);
        idle();
        step_n("late_rd0_after", 1'b1);

        // WAW: buffer rd=8 killed by slot write to r8
        mem_op(5'd8, 2'd0, 32'h0000_0001, 32'd0, 2'd2, 1'b0, 32'd0);
        late(5'd8, 32'h0000_0055);
        step_w("waw_slot", 5'd8, 32'h0000_0001, 1'b0);
        idle();
        step_n("waw_killed", 1'b1);
        step_n("waw_quiet", 1'b1);

        // Stall beats flush; flush on release empties the slot
        mem_op(5'd10, 2'd0, 32'h0000_00A0, 32'd0, 2'd2, 1'b0, 32'd0);
        step_w("stall_load", 5'd10, 32'h0000_00A0, 1'b1);
        mem_op(5'd11, 2'd0, 32'h0000_00B0, 32'd0, 2'd2, 1'b0, 32'd0);
        stall = 1'b1; flush = 1'b1;
        for (int i = 0; i < 3; i++) step_w("stall_hold", 5'd10, 32'h0000_00A0, 1'b1);
        stall = 1'b0;
        step_n("flush_release", 1'b1);
        idle();
        step_n("flush_idle", 1'b1);

        // Reset while the buffer is full: the buffered write never appears
        mem_op(5'd12, 2'd0, 32'h0000_00C0, 32'd0, 2'd2, 1'b0, 32'd0);
        late(5'd13, 32'h0000_00D0);
        step_w("rst_fill", 5'd12, 32'h0000_00C0, 1'b0);
        idle();
        reset = 1'b1;
        last_rd = 5'd0; last_data = 32'd0;
        step_n("rst_mid", 1'b1);
        reset = 1'b0;
        step_n("rst_no_late", 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
